shift_align_arb: RTL and testbench
==================================

// Module: shift_align_arb
// PURPOSE
//  Time-shares one right-shift/sticky datapath (round-toward sticky alignment shifter)
//  between two requesters, e.g. the addend-alignment and denormal-normalise paths of the
//  mul pipe. Round-robin arbitration, valid/ready on every side, one registered output
//  stage with full throughput. Shift amounts >= WIDTH saturate (all bits shifted out).
// PARAMETERS
//  WIDTH   48                  data width of operand and result
//  SWIDTH  8                   width of requested shift amount (unsigned, may exceed WIDTH)
//  AWIDTH  $clog2(WIDTH)       localparam: shift width of the internal shift datapath
// PORTS
//  clk          in   1        clock, all state on rising edge
//  rst_n        in   1        asynchronous active-low reset
//  req0_valid   in   1        requester 0 has an operand
//  req0_ready   out  1        requester 0 transfer accepted this cycle
//  req0_data    in   WIDTH    requester 0 operand
//  req0_shamt   in   SWIDTH   requester 0 right-shift amount
//  req1_valid   in   1        requester 1 has an operand
//  req1_ready   out  1        requester 1 transfer accepted this cycle
//  req1_data    in   WIDTH    requester 1 operand
//  req1_shamt   in   SWIDTH   requester 1 right-shift amount
//  out_valid    out  1        result register holds a valid result
//  out_ready    in   1        consumer takes the result this cycle
//  out_data     out  WIDTH    logically right-shifted operand (zero fill)
//  out_sticky   out  1        OR of all bits shifted out
//  out_id       out  1        index of requester that produced out_data
// BEHAVIOUR
//  Reset (rst_n=0, async): out_valid=0, out_data=0, out_sticky=0, out_id=0, rr_ptr=0.
//   req*_ready is 0 while in reset. Reset mid-transfer discards the held result.
//  Stage free: free = !out_valid || out_ready (combinational; result may be replaced in
//   the same cycle it is consumed -> 1 result/cycle sustained).
//  Arbitration (combinational, evaluated every cycle):
//   - only req0_valid -> grant 0; only req1_valid -> grant 1; neither -> no grant.
//   - both valid -> grant rr_ptr.
//   - reqN_ready = free && grant==N. At most one ready high per cycle.
//   - ready never depends on the ungranted requester's data/shamt.
//  Accept = granted valid && free. On accept (next edge): out_valid<=1, out_data,
//   out_sticky<=shift result of granted operand, out_id<=grant, rr_ptr<=~grant.
//   rr_ptr is unchanged on cycles without accept (back-pressure keeps priority).
//  If free && no valid request: out_valid<=0 at next edge (result consumed, none new).
//  If !free: output registers hold all fields stable; no request is accepted.
//  Latency: 1 cycle from accept to out_valid.
//  Shift rules (s = shamt, d = data):
//   - s==0 -> out_data=d, out_sticky=0.
//   - 0<s<WIDTH -> out_data = d>>s, out_sticky = |d[s-1:0].
//   - s>=WIDTH (any upper SWIDTH bits set, or low bits >= WIDTH) -> out_data=0,
//     out_sticky=|d. Saturation decision is made before truncating to AWIDTH bits.
//  Requester protocol: valid must stay high and data/shamt stable until ready; the block
//   does not latch an unaccepted request. Violations are not detected.
//  Simultaneous out_ready and new accept: old result leaves, new result appears next
//   cycle; out_valid stays 1 with no bubble.
// TESTING
//  1. WIDTH=48, req0 d=0x0000_0000_00FF s=4, out_ready=1 -> next cycle out_data=0xF,
//     out_sticky=1, out_id=0; req0_ready high in accept cycle.
//  2. Both valid every cycle, out_ready=1 from reset -> grants 0,1,0,1...; out_id
//     alternates, one result per cycle, no bubbles.
//  3. out_ready=0 for 5 cycles with out_valid=1 -> out_* stable, both ready low, rr_ptr
//     unchanged; release -> pending winner accepted in release cycle.
//  4. s=0 -> data unchanged, sticky 0; s=47 d=1<<47 -> out_data=1, sticky 0; s=48 and
//     s=200 with d=1 -> out_data=0, sticky=1; d=0 s=200 -> out_data=0, sticky=0.
//  5. Assert rst_n=0 asynchronously (mid-cycle) while out_valid=1 and both requesting ->
//     out_valid=0 immediately, readys low; after release req0 wins first conflict.
//  6. Random valid/ready/shamt vs reference model (>>, sticky OR) for 10k transfers:
//     every accepted request appears exactly once, in accept order, with correct id.

Source files
------------

// File: rtl/shift_align_arb.sv
// shift_align_arb: round-robin arbiter sharing one right-shift/sticky alignment stage
module shift_align_arb #(
  parameter int WIDTH = 48,
  parameter int SWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_data,
  input  logic [SWIDTH-1:0] req0_shamt,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_data,
  input  logic [SWIDTH-1:0] req1_shamt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_sticky,
  output logic              out_id
);
  localparam int AWIDTH = $clog2(WIDTH);
  logic free, any, grant, acc, sat, sticky, rr_ptr;
  logic [WIDTH-1:0] d, shifted, lost;
  logic [SWIDTH-1:0] s;
  logic [AWIDTH-1:0] sh;
  always_comb begin
    free = !out_valid || out_ready;
    any = req0_valid || req1_valid;
    grant = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
    acc = rst_n && free && any;
    req0_ready = acc && !grant;
    req1_ready = acc && grant;
    d = grant ? req1_data : req0_data;
    s = grant ? req1_shamt : req0_shamt;
    // saturate on the full-width amount before truncating to the datapath shift width
    sat = 32'(s) >= WIDTH;
    sh = s[AWIDTH-1:0];
    shifted = d >> sh;
    lost = d & ~({WIDTH{1'b1}} << sh);
    sticky = sat ? |d : |lost;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sticky <= 1'b0;
      out_id <= 1'b0;
      rr_ptr <= 1'b0;
    end else if (acc) begin
      out_valid <= 1'b1;
      out_data <= sat ? '0 : shifted;
      out_sticky <= sticky;
      out_id <= grant;
      rr_ptr <= !grant;
    end else if (free) begin
      out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_shift_align_arb.sv
// tb_shift_align_arb: directed + random stimulus, reference arbiter/shift model feeds a scoreboard
module tb_shift_align_arb;
  localparam int W = 48;
  localparam int SW = 8;
  typedef struct {logic [W-1:0] data; logic sticky; logic id;} res_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0, out_ready = 1'b0;
  logic req0_ready, req1_ready, out_valid, out_sticky, out_id;
  logic [W-1:0] req0_data = '0, req1_data = '0, out_data;
  logic [SW-1:0] req0_shamt = '0, req1_shamt = '0;
  int checks = 0, failures = 0, n_acc = 0;
  res_t sb[$];
  logic m_ov = 1'b0, m_rr = 1'b0;
  logic hold = 1'b0, h_sticky, h_id;
  logic [W-1:0] h_data;

  shift_align_arb dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_shamt(req1_shamt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sticky(out_sticky), .out_id(out_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic res_t ref_shift(input logic [W-1:0] d, input int s, input logic id);
    res_t r;
    r.data = '0;
    r.sticky = 1'b0;
    r.id = id;
    for (int i = 0; i < W; i++) begin
      if (i < s) r.sticky |= d[i];
      if (i + s < W) r.data[i] = d[i + s];
    end
    return r;
  endfunction

  // reference arbiter: checks handshakes and pushes expected results on accept
  always @(negedge clk) begin
    logic free, any, g;
    if (!rst_n) begin
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_valid", out_valid, 0);
      m_ov = 1'b0;
      m_rr = 1'b0;
      sb.delete();
    end else begin
      chk("out_valid", out_valid, m_ov);
      free = !m_ov || out_ready;
      any = req0_valid || req1_valid;
      g = (req0_valid && req1_valid) ? m_rr : req1_valid;
      chk("ready0", req0_ready, free && any && !g);
      chk("ready1", req1_ready, free && any && g);
      if (free && any) begin
        sb.push_back(g ? ref_shift(req1_data, int'(req1_shamt), 1'b1)
                       : ref_shift(req0_data, int'(req0_shamt), 1'b0));
        m_rr = !g;
        m_ov = 1'b1;
        n_acc++;
      end else if (free) begin
        m_ov = 1'b0;
      end
    end
  end

  // monitor: pops on every output handshake, checks stalled outputs stay stable
  always @(negedge clk) begin
    res_t e;
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_data", out_data, h_data);
        chk("hold_sticky", out_sticky, h_sticky);
        chk("hold_id", out_id, h_id);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_pop: got unexpected result 0x%0h expected none at %0t", out_data, $time);
        end else begin
          e = sb.pop_front();
          chk("sb_data", out_data, e.data);
          chk("sb_sticky", out_sticky, e.sticky);
          chk("sb_id", out_id, e.id);
        end
      end
      hold = out_valid && !out_ready;
      h_data = out_data;
      h_sticky = out_sticky;
      h_id = out_id;
    end
  end

  task automatic do_one(input logic id, input logic [W-1:0] d, input logic [SW-1:0] s,
                        input logic [W-1:0] ed, input logic es);
    out_ready = 1'b1;
    if (id) begin req1_valid = 1'b1; req1_data = d; req1_shamt = s; end
    else begin req0_valid = 1'b1; req0_data = d; req0_shamt = s; end
    @(negedge clk);
    chk("dir_ready", id ? req1_ready : req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("dir_valid", out_valid, 1);
    chk("dir_data", out_data, ed);
    chk("dir_sticky", out_sticky, es);
    chk("dir_id", out_id, id);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [SW-1:0] rnd_s();
    int k = $urandom_range(0, 3);
    return k == 0 ? SW'(0) : k == 1 ? SW'(46 + $urandom_range(0, 3)) :
           k == 2 ? SW'($urandom_range(1, 47)) : SW'($urandom_range(0, 255));
  endfunction

  function automatic logic [W-1:0] rnd_d();
    logic [63:0] r = {$urandom(), $urandom()};
    return $urandom_range(0, 7) == 0 ? '0 : r[W-1:0];
  endfunction

  initial begin
    logic h, a0, a1;
    int base;
    req0_valid = 1'b1;
    @(negedge clk);
    chk("rst_data", out_data, 0);
    chk("rst_sticky", out_sticky, 0);
    chk("rst_id", out_id, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst_n = 1'b1;
    do_one(0, 48'hFF, 4, 48'hF, 1);
    do_one(1, 48'h1234_5678_9ABC, 0, 48'h1234_5678_9ABC, 0);
    do_one(0, 48'h8000_0000_0000, 47, 48'h1, 0);
    do_one(1, 48'h1, 48, 48'h0, 1);
    do_one(0, 48'h1, 200, 48'h0, 1);
    do_one(1, 48'h0, 200, 48'h0, 0);
    do_one(1, 48'hF000_0000_0010, 5, 48'h0780_0000_0000, 1);
    do_one(0, 48'hF000_0000_0010, 4, 48'h0F00_0000_0001, 0);
    do_one(0, 48'hFFFF_FFFF_FFFF, 16, 48'h0000_FFFF_FFFF, 1);
    // both requesting from reset: strict alternation, no bubbles
    do_reset();
    req0_valid = 1'b1; req0_data = 48'hABC0; req0_shamt = 4;
    req1_valid = 1'b1; req1_data = 48'h1_0001; req1_shamt = 16;
    out_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("alt_valid", out_valid, 1);
      chk("alt_id", out_id, k[0]);
    end
    // back-pressure: everything holds, then the pending winner goes first
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    h = out_id;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_ready0", req0_ready, 0);
      chk("stall_ready1", req1_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_winner", h ? req0_ready : req1_ready, 1);
    // asynchronous mid-cycle reset
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_ready0", req0_ready, 0);
    chk("arst_ready1", req1_ready, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_r0", req0_ready, 1);
    chk("post_rst_r1", req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    // random traffic with protocol-respecting requesters
    base = n_acc;
    for (int c = 0; c < 40000 && n_acc - base < 10000; c++) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (!req0_valid || a0) begin
        req0_valid = $urandom_range(0, 3) != 0; req0_data = rnd_d(); req0_shamt = rnd_s();
      end
      if (!req1_valid || a1) begin
        req1_valid = $urandom_range(0, 3) != 0; req1_data = rnd_d(); req1_shamt = rnd_s();
      end
      out_ready = $urandom_range(0, 3) != 0;
    end
    chk("rand_transfers", n_acc - base >= 10000, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
